// File: rtl/jpeg_mcu_seq.sv
// jpeg_mcu_seq: walks a JPEG scan block by block (MCU column, MCU row,
// block within MCU) after the SOF parser publishes the frame geometry.
// It hands one 8x8 block descriptor at a time to the entropy/dequant stage
// and handles restart intervals and end of frame.
module jpeg_mcu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_clr,
    input  logic        co_en,
    input  logic        co_411,
    input  logic [12:0] co_mcu_w,
    input  logic [12:0] co_mcu_h,
    input  logic [1:0]  sof_y_qt,
    input  logic [1:0]  sof_cb_qt,
    input  logic [1:0]  sof_cr_qt,
    input  logic [15:0] rst_intv,
    input  logic        blk_done,
    input  logic        rstm_ack,
    output logic        blk_vld,
    output logic [1:0]  blk_comp,
    output logic [2:0]  blk_idx,
    output logic [1:0]  blk_qt,
    output logic [12:0] mcu_x,
    output logic [12:0] mcu_y,
    output logic        mcu_last,
    output logic        dc_clr,
    output logic        rstm_req,
    output logic        frame_done,
    output logic        geo_err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
        S_WAIT_RST = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Frame configuration captured from the SOF parser
    logic        cfg_411_q, cfg_411_d;
    logic [12:0] cfg_w_q, cfg_w_d;
    logic [12:0] cfg_h_q, cfg_h_d;
    logic [1:0]  qt_y_q, qt_y_d;
    logic [1:0]  qt_cb_q, qt_cb_d;
    logic [1:0]  qt_cr_q, qt_cr_d;
    logic [15:0] intv_q, intv_d;

    // Scan position and restart bookkeeping
    logic [2:0]  idx_q, idx_d;
    logic [12:0] x_q, x_d;
    logic [12:0] y_q, y_d;
    logic [15:0] rcnt_q, rcnt_d;

    // Registered descriptor/status outputs
    logic        vld_q, vld_d;
    logic [1:0]  comp_q, comp_d;
    logic [1:0]  qt_q, qt_d;
    logic        last_q, last_d;
    logic        dc_clr_q, dc_clr_d;
    logic        rstm_req_q, rstm_req_d;
    logic        frame_done_q, frame_done_d;
    logic        geo_err_q, geo_err_d;

    logic [2:0]  last_idx;
    logic [2:0]  idx_inc;
    logic [12:0] w_m1;
    logic [12:0] h_m1;
    logic [15:0] rcnt_inc;

    // Component carried by a block index: 4:2:0 has four luma blocks first.
    function automatic logic [1:0] comp_of(input logic [2:0] idx, input logic is411);
        if (is411) begin
            if (idx < 3'd4)
                return 2'd0;
            else if (idx == 3'd4)
                return 2'd1;
            else
                return 2'd2;
        end
        return idx[1:0];
    endfunction

    function automatic logic [1:0] qt_of(input logic [1:0] comp, input logic [1:0] qy,
                                         input logic [1:0] qcb, input logic [1:0] qcr);
        case (comp)
            2'd0:    return qy;
            2'd1:    return qcb;
            default: return qcr;
        endcase
    endfunction

    assign last_idx = cfg_411_q ? 3'd5 : 3'd2;
    assign idx_inc  = idx_q + 3'd1;
    assign w_m1     = cfg_w_q - 13'd1;
    assign h_m1     = cfg_h_q - 13'd1;
    assign rcnt_inc = rcnt_q + 16'd1;

    // Next-state, counter and output decode for the scan sequencer
    always_comb begin
        state_d      = state_q;
        cfg_411_d    = cfg_411_q;
        cfg_w_d      = cfg_w_q;
        cfg_h_d      = cfg_h_q;
        qt_y_d       = qt_y_q;
        qt_cb_d      = qt_cb_q;
        qt_cr_d      = qt_cr_q;
        intv_d       = intv_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        rcnt_d       = rcnt_q;
        vld_d        = vld_q;
        comp_d       = comp_q;
        qt_d         = qt_q;
        last_d       = last_q;
        dc_clr_d     = 1'b0;
        rstm_req_d   = rstm_req_q;
        frame_done_d = frame_done_q;
        geo_err_d    = geo_err_q;

        case (state_q)
            S_IDLE: begin
                if (co_en) begin
                    cfg_411_d = co_411;
                    cfg_w_d   = co_mcu_w;
                    cfg_h_d   = co_mcu_h;
                    qt_y_d    = sof_y_qt;
                    qt_cb_d   = sof_cb_qt;
                    qt_cr_d   = sof_cr_qt;
                    intv_d    = rst_intv;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cfg_w_q == 13'd0 || cfg_h_q == 13'd0) begin
                    geo_err_d    = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    idx_d    = 3'd0;
                    x_d      = 13'd0;
                    y_d      = 13'd0;
                    rcnt_d   = 16'd0;
                    comp_d   = 2'd0;
                    qt_d     = qt_y_q;
                    last_d   = 1'b0;
                    vld_d    = 1'b1;
                    dc_clr_d = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (blk_done) begin
                    if (idx_q != last_idx) begin
                        // Next block inside the same MCU
                        idx_d  = idx_inc;
                        comp_d = comp_of(idx_inc, cfg_411_q);
                        qt_d   = qt_of(comp_of(idx_inc, cfg_411_q), qt_y_q, qt_cb_q, qt_cr_q);
                        last_d = (idx_inc == last_idx);
                    end else begin
                        // MCU complete
                        rcnt_d = rcnt_inc;
                        if (x_q == w_m1 && y_q == h_m1) begin
                            vld_d        = 1'b0;
                            frame_done_d = 1'b1;
                            state_d      = S_DONE;
                        end else begin
                            idx_d  = 3'd0;
                            comp_d = 2'd0;
                            qt_d   = qt_y_q;
                            last_d = 1'b0;
                            if (x_q == w_m1) begin
                                x_d = 13'd0;
                                y_d = y_q + 13'd1;
                            end else begin
                                x_d = x_q + 13'd1;
                            end
                            if (intv_q != 16'd0 && rcnt_inc == intv_q) begin
                                vld_d      = 1'b0;
                                rstm_req_d = 1'b1;
                                state_d    = S_WAIT_RST;
                            end
                        end
                    end
                end
            end
            S_WAIT_RST: begin
                if (rstm_ack) begin
                    rstm_req_d = 1'b0;
                    rcnt_d     = 16'd0;
                    vld_d      = 1'b1;
                    dc_clr_d   = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; either clear returns everything to idle
    always_ff @(posedge clk) begin
        if (rst || frame_clr) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            x_q          <= 13'd0;
            y_q          <= 13'd0;
            rcnt_q       <= 16'd0;
            vld_q        <= 1'b0;
            comp_q       <= 2'd0;
            qt_q         <= 2'd0;
            last_q       <= 1'b0;
            dc_clr_q     <= 1'b0;
            rstm_req_q   <= 1'b0;
            frame_done_q <= 1'b0;
            geo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rcnt_q       <= rcnt_d;
            vld_q        <= vld_d;
            comp_q       <= comp_d;
            qt_q         <= qt_d;
            last_q       <= last_d;
            dc_clr_q     <= dc_clr_d;
            rstm_req_q   <= rstm_req_d;
            frame_done_q <= frame_done_d;
            geo_err_q    <= geo_err_d;
        end
    end

    // Frame configuration holds until the next co_en in IDLE
    always_ff @(posedge clk) begin
        cfg_411_q <= cfg_411_d;
        cfg_w_q   <= cfg_w_d;
        cfg_h_q   <= cfg_h_d;
        qt_y_q    <= qt_y_d;
        qt_cb_q   <= qt_cb_d;
        qt_cr_q   <= qt_cr_d;
        intv_q    <= intv_d;
    end

    assign blk_vld    = vld_q;
    assign blk_comp   = comp_q;
    assign blk_idx    = idx_q;
    assign blk_qt     = qt_q;
    assign mcu_x      = x_q;
    assign mcu_y      = y_q;
    assign mcu_last   = last_q;
    assign dc_clr     = dc_clr_q;
    assign rstm_req   = rstm_req_q;
    assign frame_done = frame_done_q;
    assign geo_err    = geo_err_q;

endmodule

// File: tb/tb_jpeg_mcu_seq.sv
// Bench for jpeg_mcu_seq: a reference model expands each frame into the
// expected descriptor list; a monitor pops and compares on every accepted block.
module tb_jpeg_mcu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, frame_clr, co_en, co_411;
    logic [12:0] co_mcu_w, co_mcu_h;
    logic [1:0]  sof_y_qt, sof_cb_qt, sof_cr_qt;
    logic [15:0] rst_intv;
    logic        blk_done, rstm_ack;
    logic        blk_vld;
    logic [1:0]  blk_comp;
    logic [2:0]  blk_idx;
    logic [1:0]  blk_qt;
    logic [12:0] mcu_x, mcu_y;
    logic        mcu_last, dc_clr, rstm_req, frame_done, geo_err;

    jpeg_mcu_seq dut (
        .clk(clk), .rst(rst), .frame_clr(frame_clr), .co_en(co_en), .co_411(co_411),
        .co_mcu_w(co_mcu_w), .co_mcu_h(co_mcu_h), .sof_y_qt(sof_y_qt),
        .sof_cb_qt(sof_cb_qt), .sof_cr_qt(sof_cr_qt), .rst_intv(rst_intv),
        .blk_done(blk_done), .rstm_ack(rstm_ack), .blk_vld(blk_vld),
        .blk_comp(blk_comp), .blk_idx(blk_idx), .blk_qt(blk_qt), .mcu_x(mcu_x),
        .mcu_y(mcu_y), .mcu_last(mcu_last), .dc_clr(dc_clr), .rstm_req(rstm_req),
        .frame_done(frame_done), .geo_err(geo_err)
    );

    // kind: 0 = scan continues, 1 = restart marker follows, 2 = end of frame
    typedef struct {
        logic [1:0]  comp;
        logic [2:0]  idx;
        logic [1:0]  qt;
        logic [12:0] x;
        logic [12:0] y;
        logic        last;
        int          kind;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   dc_seen = 0;
    int   rr_seen = 0;
    int   pend = 0;
    logic rr_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    endtask

    task automatic zero_chk(input string pfx);
        chk({pfx, "_pos"}, {6'd0, mcu_x, mcu_y}, 32'd0);
        chk({pfx, "_ctl"}, {16'd0, blk_vld, blk_comp, blk_idx, blk_qt, mcu_last,
                            dc_clr, rstm_req, frame_done, geo_err}, 32'd0);
    endtask

    // Expected scan: raster over MCUs, fixed block order inside each MCU.
    // Returns the number of restart markers the frame should request.
    function automatic int build_model(input logic is411, input int w, input int h,
                                       input logic [1:0] qy, input logic [1:0] qcb,
                                       input logic [1:0] qcr, input int intv);
        int nb;
        int cnt;
        int rs;
        int c;
        exp_t e;
        logic [1:0] qts [3];
        qts[0] = qy; qts[1] = qcb; qts[2] = qcr;
        nb = is411 ? 6 : 3;
        cnt = 0;
        rs = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                for (int b = 0; b < nb; b++) begin
                    c      = is411 ? ((b < 4) ? 0 : b - 3) : b;
                    e.comp = 2'(c);
                    e.idx  = 3'(b);
                    e.qt   = qts[c];
                    e.x    = 13'(x);
                    e.y    = 13'(y);
                    e.last = (b == nb - 1);
                    e.kind = 0;
                    if (b == nb - 1) begin
                        cnt++;
                        if (x == w - 1 && y == h - 1) e.kind = 2;
                        else if (intv != 0 && cnt == intv) begin
                            e.kind = 1;
                            cnt = 0;
                            rs++;
                        end
                    end
                    expq.push_back(e);
                end
            end
        end
        return rs;
    endfunction

    // Monitor: checks the cycle after each handshake, pops on accepted blocks
    always @(negedge clk) begin
        case (pend)
            1: begin
                chk("advance_vld", {31'd0, blk_vld}, 32'd1);
                chk("advance_no_dc", {31'd0, dc_clr}, 32'd0);
            end
            2: chk("restart_entry {rstm_req,blk_vld}", {30'd0, rstm_req, blk_vld}, 32'd2);
            3: chk("eof {frame_done,blk_vld,rstm_req}", {29'd0, frame_done, blk_vld, rstm_req}, 32'd4);
            4: chk("ack_exit {rstm_req,blk_vld,dc_clr}", {29'd0, rstm_req, blk_vld, dc_clr}, 32'd3);
            default: ;
        endcase
        pend = 0;
        if (!(rst || frame_clr)) begin
            if (dc_clr) dc_seen++;
            if (rstm_req && !rr_prev) rr_seen++;
            chk("vld_req_exclusive", {31'd0, blk_vld & rstm_req}, 32'd0);
            if (expq.size() == 0) begin
                chk("unexpected_vld", {31'd0, blk_vld}, 32'd0);
            end else if (blk_vld && blk_done) begin
                mon_e = expq.pop_front();
                chk("desc_pos {x,y}", {6'd0, mcu_x, mcu_y}, {6'd0, mon_e.x, mon_e.y});
                chk("desc_blk {comp,idx,qt,last}", {24'd0, blk_comp, blk_idx, blk_qt, mcu_last},
                    {24'd0, mon_e.comp, mon_e.idx, mon_e.qt, mon_e.last});
                pend = (mon_e.kind == 0) ? 1 : (mon_e.kind == 1) ? 2 : 3;
            end
            if (rstm_req && rstm_ack) pend = 4;
        end
        rr_prev = rstm_req;
    end

    // One frame: spacing <0 random blk_done, else blk_done after `spacing` idle cycles.
    // clr_after >= 0 aborts the frame with frame_clr (or rst) after that many blocks.
    task automatic run_frame(input logic is411, input int w, input int h, input logic [1:0] qy,
                             input logic [1:0] qcb, input logic [1:0] qcr, input int intv,
                             input int spacing, input int clr_after, input logic use_rst);
        int   rs, hs, gap, cyc;
        logic vb;
        expq.delete();
        rs = build_model(is411, w, h, qy, qcb, qcr, intv);
        dc_seen = 0;
        rr_seen = 0;
        // handshakes in IDLE must be ignored
        blk_done = 1'b1; rstm_ack = 1'b1;
        @(posedge clk); #1;
        chk("idle_hold {blk_vld,frame_done,mcu_x}", {18'd0, blk_vld, frame_done, mcu_x}, 32'd0);
        blk_done = 1'b0; rstm_ack = 1'b0;
        co_en = 1'b1; co_411 = is411; co_mcu_w = 13'(w); co_mcu_h = 13'(h);
        sof_y_qt = qy; sof_cb_qt = qcb; sof_cr_qt = qcr; rst_intv = 16'(intv);
        @(posedge clk); #1;
        chk("load_no_vld", {31'd0, blk_vld}, 32'd0);
        // co_en stays high with different geometry: must not be re-latched
        co_411 = ~is411; co_mcu_w = 13'($urandom_range(1, 9)); co_mcu_h = 13'($urandom_range(1, 9));
        sof_y_qt = 2'($urandom); sof_cb_qt = 2'($urandom); sof_cr_qt = 2'($urandom);
        rst_intv = 16'($urandom_range(1, 3));
        @(posedge clk); #1;
        chk("start {vld,dc_clr,idx,x,y}", {1'b0, blk_vld, dc_clr, blk_idx, mcu_x, mcu_y},
            {1'b0, 1'b1, 1'b1, 3'd0, 13'd0, 13'd0});
        hs = 0; gap = 0; cyc = 0;
        while (!frame_done && cyc < 4000) begin
            if (clr_after >= 0 && hs == clr_after) break;
            if (blk_vld) blk_done = (spacing < 0) ? ($urandom_range(0, 2) == 0) : (gap >= spacing);
            else         blk_done = ($urandom_range(0, 1) == 1);
            rstm_ack = ($urandom_range(0, 3) == 0);
            vb = blk_vld;
            @(posedge clk); #1;
            cyc++;
            if (vb && blk_done) begin hs++; gap = 0; end
            else if (vb) gap++;
        end
        blk_done = 1'b0; rstm_ack = 1'b0;
        if (clr_after >= 0) begin
            co_en = 1'b0;
            chk("clear_point_reached", 32'(hs), 32'(clr_after));
            if (use_rst) rst = 1'b1; else frame_clr = 1'b1;
            blk_done = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; frame_clr = 1'b0; blk_done = 1'b0;
            zero_chk(use_rst ? "midframe_rst" : "midframe_clr");
            expq.delete();
            return;
        end
        chk("frame_done_in_budget", {31'd0, frame_done}, 32'd1);
        chk("model_drained", 32'(expq.size()), 32'd0);
        chk("dc_clr_count", 32'(dc_seen), 32'(rs + 1));
        chk("rstm_req_count", 32'(rr_seen), 32'(rs));
        chk("no_geo_err", {31'd0, geo_err}, 32'd0);
        // handshakes and co_en in DONE must be ignored
        blk_done = 1'b1; rstm_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold {fd,vld,req}", {29'd0, frame_done, blk_vld, rstm_req}, 32'd4);
        chk("done_hold {x,y}", {6'd0, mcu_x, mcu_y}, {6'd0, 13'(w - 1), 13'(h - 1)});
        blk_done = 1'b0; rstm_ack = 1'b0; co_en = 1'b0;
        frame_clr = 1'b1;
        @(posedge clk); #1;
        frame_clr = 1'b0;
        zero_chk("after_frame_clr");
    endtask

    task automatic run_bad(input int w, input int h);
        expq.delete();
        co_en = 1'b1; co_411 = 1'($urandom_range(0, 1));
        co_mcu_w = 13'(w); co_mcu_h = 13'(h); rst_intv = 16'd0;
        @(posedge clk); #1;
        chk("bad_load {geo_err,frame_done,vld}", {29'd0, geo_err, frame_done, blk_vld}, 32'd0);
        @(posedge clk); #1;
        chk("bad_err {geo_err,frame_done,vld}", {29'd0, geo_err, frame_done, blk_vld}, 32'd6);
        blk_done = 1'b1; rstm_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bad_hold {geo_err,frame_done,vld}", {29'd0, geo_err, frame_done, blk_vld}, 32'd6);
        co_en = 1'b0; blk_done = 1'b0; rstm_ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        zero_chk("bad_after_rst");
    endtask

    initial begin
        rst = 1'b1; frame_clr = 1'b0; co_en = 1'b0; co_411 = 1'b0;
        co_mcu_w = 13'd0; co_mcu_h = 13'd0; sof_y_qt = 2'd0; sof_cb_qt = 2'd0; sof_cr_qt = 2'd0;
        rst_intv = 16'd0; blk_done = 1'b0; rstm_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        zero_chk("reset");
        rst = 1'b0;

        run_frame(1'b1, 2, 1, 2'd0, 2'd1, 2'd1, 0, 0, -1, 1'b0);
        run_frame(1'b0, 3, 2, 2'd2, 2'd3, 2'd1, 0, 4, -1, 1'b0);
        run_frame(1'b0, 5, 1, 2'd1, 2'd2, 2'd3, 2, -1, -1, 1'b0);
        run_bad(0, 4);
        run_bad(3, 0);
        run_frame(1'b1, 2, 1, 2'd0, 2'd1, 2'd1, 0, 0, 7, 1'b0);
        run_frame(1'b1, 2, 1, 2'd0, 2'd1, 2'd1, 0, 0, -1, 1'b0);
        run_frame(1'b0, 4, 2, 2'd3, 2'd0, 2'd2, 3, -1, 5, 1'b1);
        run_frame(1'b0, 4, 2, 2'd3, 2'd0, 2'd2, 3, -1, -1, 1'b0);
        run_frame(1'b1, 1, 1, 2'd1, 2'd2, 2'd3, 1, 0, -1, 1'b0);
        run_frame(1'b0, 3, 1, 2'd2, 2'd1, 2'd0, 65535, 0, -1, 1'b0);
        run_frame(1'b1, 3, 3, 2'd1, 2'd3, 2'd0, 1, -1, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_frame(1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 3),
                      2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 4),
                      $urandom_range(0, 3) == 3 ? -1 : $urandom_range(0, 2), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jpeg_mcu_seq.md
# jpeg_mcu_seq

MCU/block sequencer sitting directly downstream of the SOF parser. Latches the frame geometry and per-component quantisation-table selectors once the SOF parser raises `co_en`. It then walks the scan in decode order: MCU column, MCU row, and block within MCU. For each 8x8 block it presents the component, block index, QT selector and MCU position to the entropy/dequant stage, advances on that stage's `blk_done`, and handles restart intervals and end of frame.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `frame_clr`  in  1  synchronous clear pulse at start of a new image; same effect as `rst`.
- `co_en`  in  1  SOF geometry valid (level); `co_mcu_w`/`co_mcu_h` are valid in the same cycle.
- `co_411`  in  1  1 = 4:2:0 (16x16 MCU, 6 blocks); 0 = 4:4:4 (8x8 MCU, 3 blocks).
- `co_mcu_w`  in  13  MCUs per row.
- `co_mcu_h`  in  13  MCU rows.
- `sof_y_qt`, `sof_cb_qt`, `sof_cr_qt`  in  2 each  QT selectors.
- `rst_intv`  in  16  restart interval in MCUs (DRI); 0 = disabled; sampled with geometry.
- `blk_done`  in  1  downstream finished current block (pulse).
- `rstm_ack`  in  1  downstream consumed RSTn marker (pulse).
- `blk_vld`  out  1  block descriptor valid.
- `blk_comp`  out  2  0 = Y, 1 = Cb, 2 = Cr.
- `blk_idx`  out  3  block index within MCU, 0..5 or 0..2.
- `blk_qt`  out  2  QT selector for `blk_comp`.
- `mcu_x`  out  13  current MCU column.
- `mcu_y`  out  13  current MCU row.
- `mcu_last`  out  1  high while the current block is the last block of its MCU.
- `dc_clr`  out  1  one-cycle pulse: clear all DC predictors.
- `rstm_req`  out  1  level: expecting a restart marker.
- `frame_done`  out  1  level: all MCUs consumed.
- `geo_err`  out  1  level: zero MCU width or height.

## Operation
- **FSM states:** IDLE, LOAD, RUN, WAIT_RST, DONE.
- **IDLE:**
  - On the first cycle with `co_en`=1, latch `co_411`, `co_mcu_w`, `co_mcu_h`, the three QT selectors and `rst_intv`.
  - Go to LOAD.
- **LOAD (1 cycle):**
  - If latched width or height is 0: set `geo_err`=1 and `frame_done`=1, go to DONE.
  - Otherwise: clear position and block counters, pulse `dc_clr`, go to RUN.
- **Block order per MCU:**
  - `co_411`=1: idx 0-3 Y, 4 Cb, 5 Cr.
  - `co_411`=0: idx 0 Y, 1 Cb, 2 Cr.
  - `blk_qt` is taken from the matching latched selector.
- **RUN:**
  - `blk_vld`=1. The block advances when `blk_done`=1.
  - On the last block of an MCU: `blk_idx` returns to 0 and `mcu_x` increments.
  - When `mcu_x` = w-1: `mcu_x` returns to 0 and `mcu_y` increments.
  - A 16-bit MCU counter since the last restart increments on every MCU completion.
- **Restart:**
  - Trigger: `rst_intv`≠0, the completed MCU count equals `rst_intv`, and the completed MCU was not the last of the frame.
  - Action: go to WAIT_RST with `rstm_req`=1 and `blk_vld`=0.
  - On `rstm_ack`: clear the MCU counter, pulse `dc_clr`, return to RUN.
- **End of frame:** `blk_done` on the last block of MCU (w-1, h-1) goes to DONE. In DONE, `blk_vld`=0 and `frame_done`=1; the block stays there until `frame_clr` or `rst`.
- **Ignored inputs:**
  - `blk_done` when `blk_vld`=0.
  - `rstm_ack` outside WAIT_RST.
  - `co_en` outside IDLE.
- **Clear priority:** `rst` > `frame_clr` > all else. Either clear, at any time including mid-frame, returns the block to IDLE with all outputs at reset values.

## Timing
- **Reset values:** every output is 0; state is IDLE.
- **Start-up latency:** `co_en` sampled at edge N puts the block in LOAD at N+1, with `blk_vld`=1 and `dc_clr`=1 at N+2.
  - The `dc_clr` pulse is coincident with the first `blk_vld` cycle.
- **Advance latency:** a `blk_done` sampled at edge N gives new descriptors at N+1. Back-to-back `blk_done` every cycle is supported at one block/cycle.
- **Restart timing:**
  - `rstm_req` rises the cycle after the triggering `blk_done`.
  - `rstm_ack` at edge N gives `rstm_req`=0, `blk_vld`=1 and `dc_clr`=1 at N+1.
  - `rstm_ack` coincident with the WAIT_RST entry edge is ignored.
- **Registered outputs:** all outputs are registered. `mcu_last` is registered and is consistent with `blk_idx`.
- **Arithmetic:**
  - Position counters are 13-bit and never exceed w-1 / h-1.
  - The restart counter is 16-bit and compared for equality, so `rst_intv`=65535 is legal.

## Test plan
1. **4:2:0 frame:** `co_411`=1, w=2, h=1, QT y=0 / cb=1 / cr=1, `blk_done` every cycle.
   - 12 descriptors with comp 0,0,0,0,1,2 twice; `mcu_x` 0 then 1.
   - `frame_done` one cycle after the 12th `blk_done`.
2. **4:4:4 frame:** `co_411`=0, w=3, h=2, `blk_done` spaced 5 cycles.
   - 18 blocks in raster order; `mcu_last` on every idx 2.
   - `mcu_y` increments after (x=2, y=0).
3. **Restart interval:** `rst_intv`=2, 4:4:4, w=5, h=1.
   - `rstm_req` after MCUs 2 and 4 only, none after the final MCU 5.
   - `dc_clr` pulses 3 times total.
4. **Bad geometry:** w=0, h=4.
   - `geo_err`=1 and `frame_done`=1 two cycles after `co_en`.
   - `blk_vld` never asserts.
5. **Mid-frame clear:** `frame_clr` during block 7 of test 1.
   - Next cycle all outputs are 0.
   - A new `co_en` restarts from (0,0) with idx 0.
6. **Spurious handshakes:** `blk_done` in IDLE/WAIT_RST/DONE and `rstm_ack` in RUN.
   - No counter or state change.
